// File: rtl/jpeg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jpeg_pkg
// Description : Shared JPEG constants and the bit-packer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package jpeg_pkg;

    // Marker prefix and the stuff byte that follows an 0xFF data byte
    localparam logic [7:0] JPEG_MARK_PREFIX = 8'hFF;
    localparam logic [7:0] JPEG_STUFF       = 8'h00;
    localparam logic [7:0] JPEG_RST0        = 8'hD0;
    localparam logic [7:0] JPEG_EOI         = 8'hD9;

    // Bit-packer state encoding
    localparam int                c_ST_W         = 3;
    localparam logic [c_ST_W-1:0] c_ST_PACK      = 3'd0;
    localparam logic [c_ST_W-1:0] c_ST_STUFF     = 3'd1;
    localparam logic [c_ST_W-1:0] c_ST_PAD       = 3'd2;
    localparam logic [c_ST_W-1:0] c_ST_MARK_FF   = 3'd3;
    localparam logic [c_ST_W-1:0] c_ST_MARK_CODE = 3'd4;

endpackage : jpeg_pkg
`default_nettype wire

// File: rtl/jpeg_byte_oreg.sv
`default_nettype none
// ============================================================================
// Module      : jpeg_byte_oreg
// Description : One-entry output byte register. Holds its byte while the
//               consumer stalls; reports when a new byte may be loaded.
// Revision    : 1.0 - initial release
// ============================================================================
module jpeg_byte_oreg (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [7:0] i_data,
    input  logic       i_next,
    output logic       o_we,
    output logic [7:0] o_data,
    output logic       o_free
);

    logic       r_we;
    logic [7:0] r_data;
    logic       w_free;

    // Register is free when empty or its byte is being taken this cycle
    assign w_free = ~r_we | i_next;

    // Load a new byte (or go empty) only when free; otherwise hold
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we   <= 1'b0;
            r_data <= 8'h00;
        end else if (w_free) begin
            r_we <= i_load;
            if (i_load) begin
                r_data <= i_data;
            end
        end
    end

    assign o_we   = r_we;
    assign o_data = r_data;
    assign o_free = w_free;

endmodule : jpeg_byte_oreg
`default_nettype wire

// File: rtl/jpeg_bitpack.sv
`default_nettype none
// ============================================================================
// Module      : jpeg_bitpack
// Description : Entropy-coded-segment writer. Packs MSB-first variable-length
//               codes into bytes, stuffs 0x00 after 0xFF data bytes, 1-pads
//               and flushes before emitting FF,marker.
// Revision    : 1.0 - initial release
// ============================================================================
module jpeg_bitpack
    import jpeg_pkg::*;
#(
    parameter int CODE_W = 32,
    parameter int ACC_W  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ai_we,
    input  logic [CODE_W-1:0] ai_code,
    input  logic [5:0]        ai_len,
    input  logic              ai_marker,
    output logic              ao_next,
    output logic              bo_we,
    output logic [7:0]        bo_data,
    input  logic              bi_next
);

    localparam int c_CNT_W = $clog2(ACC_W + 1);

    logic [ACC_W-1:0]   r_acc;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_ST_W-1:0]  r_state;
    logic               r_stuff;
    logic               r_mpend;
    logic [7:0]         r_mark;

    logic [ACC_W-1:0]   w_acc_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [c_ST_W-1:0]  w_state_nxt;
    logic               w_stuff_nxt;
    logic               w_mpend_nxt;
    logic [7:0]         w_mark_nxt;
    logic [ACC_W-1:0]   w_acc_a;
    logic [c_CNT_W-1:0] w_cnt_a;

    logic               w_load;
    logic [7:0]         w_load_data;
    logic               w_free;
    logic               w_accept;
    logic [c_CNT_W-1:0] w_len_raw;
    logic [c_CNT_W-1:0] w_len;
    logic [ACC_W-1:0]   w_code;
    logic [c_CNT_W-1:0] w_shift;
    logic [ACC_W-1:0]   w_app;
    logic [c_CNT_W-1:0] w_cnt_rnd;
    logic [ACC_W-1:0]   w_fill;

    // Input side: clamp length, mask code, place it just below the valid bits
    assign w_len_raw = c_CNT_W'(ai_len);
    assign w_len     = (w_len_raw > c_CNT_W'(CODE_W)) ? c_CNT_W'(CODE_W) : w_len_raw;
    assign w_code    = ACC_W'(ai_code) & ~({ACC_W{1'b1}} << w_len);
    assign w_shift   = c_CNT_W'(ACC_W) - r_cnt - w_len;
    assign w_app     = r_acc | (w_code << w_shift);

    // Padding: ones from the last valid bit down to the next byte boundary
    assign w_cnt_rnd = (r_cnt + c_CNT_W'(7)) & {{(c_CNT_W-3){1'b1}}, 3'b000};
    assign w_fill    = ({ACC_W{1'b1}} >> r_cnt) & ~({ACC_W{1'b1}} >> w_cnt_rnd);

    // Ready depends only on registered state (and reset)
    assign ao_next  = ~rst & (r_state == c_ST_PACK) &
                      (r_cnt <= c_CNT_W'(ACC_W - CODE_W)) & ~r_stuff;
    assign w_accept = ai_we & ao_next;

    // Next-state: append, drain one byte per cycle, stuff/pad/marker sequencing
    always_comb begin
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_state_nxt = r_state;
        w_stuff_nxt = r_stuff;
        w_mpend_nxt = r_mpend;
        w_mark_nxt  = r_mark;
        w_load      = 1'b0;
        w_load_data = JPEG_STUFF;
        w_acc_a     = r_acc;
        w_cnt_a     = r_cnt;
        case (r_state)
            c_ST_PACK: begin
                if (w_accept) begin
                    if (ai_marker) begin
                        w_mark_nxt  = ai_code[7:0];
                        w_mpend_nxt = 1'b1;
                        w_state_nxt = c_ST_PAD;
                    end else begin
                        w_acc_a = w_app;
                        w_cnt_a = r_cnt + w_len;
                    end
                end
                w_acc_nxt = w_acc_a;
                w_cnt_nxt = w_cnt_a;
                // A byte completed by this cycle's accept drains immediately
                if (w_free && (w_cnt_a >= c_CNT_W'(8))) begin
                    w_load      = 1'b1;
                    w_load_data = w_acc_a[ACC_W-1 -: 8];
                    w_acc_nxt   = w_acc_a << 8;
                    w_cnt_nxt   = w_cnt_a - c_CNT_W'(8);
                    if (w_acc_a[ACC_W-1 -: 8] == JPEG_MARK_PREFIX) begin
                        w_stuff_nxt = 1'b1;
                        w_state_nxt = c_ST_STUFF;
                    end
                end
            end
            c_ST_STUFF: begin
                if (w_free) begin
                    w_load      = 1'b1;
                    w_load_data = JPEG_STUFF;
                    w_stuff_nxt = 1'b0;
                    w_state_nxt = r_mpend ? c_ST_PAD : c_ST_PACK;
                end
            end
            c_ST_PAD: begin
                if (r_cnt[2:0] != 3'd0) begin
                    w_acc_nxt = r_acc | w_fill;
                    w_cnt_nxt = w_cnt_rnd;
                end else if (r_cnt == '0) begin
                    w_state_nxt = c_ST_MARK_FF;
                end else if (w_free) begin
                    w_load      = 1'b1;
                    w_load_data = r_acc[ACC_W-1 -: 8];
                    w_acc_nxt   = r_acc << 8;
                    w_cnt_nxt   = r_cnt - c_CNT_W'(8);
                    if (r_acc[ACC_W-1 -: 8] == JPEG_MARK_PREFIX) begin
                        w_stuff_nxt = 1'b1;
                        w_state_nxt = c_ST_STUFF;
                    end
                end
            end
            c_ST_MARK_FF: begin
                if (w_free) begin
                    w_load      = 1'b1;
                    w_load_data = JPEG_MARK_PREFIX;
                    w_state_nxt = c_ST_MARK_CODE;
                end
            end
            c_ST_MARK_CODE: begin
                if (w_free) begin
                    w_load      = 1'b1;
                    w_load_data = r_mark;
                    w_mpend_nxt = 1'b0;
                    w_state_nxt = c_ST_PACK;
                end
            end
            default: begin
                w_state_nxt = c_ST_PACK;
            end
        endcase
    end

    // State and accumulator registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= c_ST_PACK;
            r_stuff <= 1'b0;
            r_mpend <= 1'b0;
            r_mark  <= 8'h00;
        end else begin
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_state <= w_state_nxt;
            r_stuff <= w_stuff_nxt;
            r_mpend <= w_mpend_nxt;
            r_mark  <= w_mark_nxt;
        end
    end

    jpeg_byte_oreg u_oreg (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_data (w_load_data),
        .i_next (bi_next),
        .o_we   (bo_we),
        .o_data (bo_data),
        .o_free (w_free)
    );

endmodule : jpeg_bitpack
`default_nettype wire

// File: tb/tb_jpeg_bitpack.sv
`default_nettype none
// ============================================================================
// Module      : tb_jpeg_bitpack
// Description : Self-checking bench for jpeg_bitpack with a bit-queue model
//               of the byte stream plus directed literal sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jpeg_bitpack;

    logic        clk = 1'b0;
    logic        rst;
    logic        ai_we;
    logic [31:0] ai_code;
    logic [5:0]  ai_len;
    logic        ai_marker;
    logic        ao_next;
    logic        bo_we;
    logic [7:0]  bo_data;
    logic        bi_next;

    int          checks = 0;
    int          errors = 0;
    bit          bq[$];
    logic [7:0]  expq[$];
    logic [7:0]  got[$];
    bit          prev_stall = 1'b0;
    logic [7:0]  prev_data  = 8'h00;
    bit          rand_bp    = 1'b0;
    bit          bp_val     = 1'b1;

    always #5 clk = ~clk;

    jpeg_bitpack #(.CODE_W(32), .ACC_W(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .ai_we     (ai_we),
        .ai_code   (ai_code),
        .ai_len    (ai_len),
        .ai_marker (ai_marker),
        .ao_next   (ao_next),
        .bo_we     (bo_we),
        .bo_data   (bo_data),
        .bi_next   (bi_next)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: pack whole bytes out of the bit queue, stuffing after FF
    task automatic model_drain();
        logic [7:0] b;
        while (bq.size() >= 8) begin
            b = 8'h00;
            for (int k = 0; k < 8; k++) b = {b[6:0], bq.pop_front()};
            expq.push_back(b);
            if (b == 8'hFF) expq.push_back(8'h00);
        end
    endtask

    task automatic model_accept(input logic [31:0] code, input int len, input bit mk);
        int l;
        if (mk) begin
            while ((bq.size() % 8) != 0) bq.push_back(1'b1);
            model_drain();
            expq.push_back(8'hFF);
            expq.push_back(code[7:0]);
        end else begin
            l = (len > 32) ? 32 : len;
            for (int i = l - 1; i >= 0; i--) bq.push_back(code[i]);
            model_drain();
        end
    endtask

    // Compare process: every transfer, hold rule, and model update on accept
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                bq.delete();
                expq.delete();
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("hold_we", 64'(bo_we), 64'd1);
                    chk("hold_data", 64'(bo_data), 64'(prev_data));
                end
                if (bo_we && bi_next) begin
                    got.push_back(bo_data);
                    if (expq.size() == 0) chk("extra_byte", 64'(bo_data), 64'h1FF);
                    else chk("stream_byte", 64'(bo_data), 64'(expq.pop_front()));
                end
                prev_stall = bo_we && !bi_next;
                prev_data  = bo_data;
                if (ai_we && ao_next) model_accept(ai_code, int'(ai_len), ai_marker);
            end
        end
    end

    // Downstream ready driver
    initial begin
        bi_next = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bi_next = rand_bp ? ($urandom_range(0, 3) != 0) : bp_val;
        end
    end

    task automatic send(input logic [31:0] code, input int len, input bit mk);
        bit done = 1'b0;
        @(posedge clk);
        #1;
        ai_code = code; ai_len = 6'(len); ai_marker = mk; ai_we = 1'b1;
        for (int i = 0; i < 1000 && !done; i++) begin
            @(negedge clk);
            if (ao_next) done = 1'b1;
            @(posedge clk);
            #1;
        end
        ai_we = 1'b0; ai_marker = 1'b0;
        if (!done) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_idle();
        bit idle = 1'b0;
        for (int i = 0; i < 500 && !idle; i++) begin
            @(negedge clk);
            if (expq.size() == 0 && !bo_we) idle = 1'b1;
        end
        if (!idle) chk("idle_timeout", 64'(expq.size()), 64'd0);
    endtask

    task automatic count_low(input int n, output int lows);
        lows = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (!ao_next) lows++;
        end
    endtask

    task automatic check_seq(input string nm, input int n,
                             input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        chk({nm, "_count"}, 64'(got.size()), 64'(n));
        for (int i = 0; i < n && i < got.size(); i++) chk(nm, 64'(got[i]), 64'(e[i]));
        got.delete();
    endtask

    initial begin
        int lows;
        logic [31:0] codes [5];
        rst = 1'b1; ai_we = 1'b0; ai_code = '0; ai_len = '0; ai_marker = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ao_next", 64'(ao_next), 64'd0);
        chk("rst_bo_we", 64'(bo_we), 64'd0);
        chk("rst_bo_data", 64'(bo_data), 64'h00);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ao_next", 64'(ao_next), 64'd1);
        got.delete();

        // 1: plain byte, no stall on input
        send(32'hAA, 8, 1'b0);
        count_low(6, lows);
        chk("t1_ao_low_cycles", 64'(lows), 64'd0);
        wait_idle();
        check_seq("t1_bytes", 1, 8'hAA, 8'h00, 8'h00, 8'h00);

        // 2: FF data byte gets 00 stuffed, one input-blocked cycle
        send(32'hFF, 8, 1'b0);
        count_low(6, lows);
        chk("t2_ao_low_cycles", 64'(lows), 64'd1);
        wait_idle();
        check_seq("t2_bytes", 2, 8'hFF, 8'h00, 8'h00, 8'h00);

        // 3: 101 padded with ones, then EOI
        send(32'h5, 3, 1'b0);
        send(32'hD9, 0, 1'b1);
        wait_idle();
        check_seq("t3_bytes", 3, 8'hBF, 8'hFF, 8'hD9, 8'h00);

        // 4: pad produces FF which is stuffed before the marker
        send(32'hF, 4, 1'b0);
        send(32'hD0, 0, 1'b1);
        wait_idle();
        check_seq("t4_bytes", 4, 8'hFF, 8'h00, 8'hFF, 8'hD0);

        // 5: downstream stalled for 20 cycles while wide codes are offered
        codes[0] = 32'h01234567; codes[1] = 32'h89ABCDEF; codes[2] = 32'h02468ACE;
        codes[3] = 32'h13579BDF; codes[4] = 32'h0F1E2D3C;
        @(posedge clk); #1; bp_val = 1'b0;
        fork
            begin
                repeat (15) @(posedge clk);
                @(negedge clk);
                chk("t5_ao_next_stalled", 64'(ao_next), 64'd0);
                repeat (5) @(posedge clk);
                bp_val = 1'b1;
            end
            begin
                for (int i = 0; i < 5; i++) send(codes[i], 32, 1'b0);
            end
        join
        wait_idle();
        chk("t5_count", 64'(got.size()), 64'd20);
        if (got.size() == 20) begin
            chk("t5_first", 64'(got[0]), 64'h01);
            chk("t5_last", 64'(got[19]), 64'h3C);
        end
        got.delete();

        // 6: reset discards buffered bits
        send(32'h1F, 5, 1'b0);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("t6_bo_we_after_rst", 64'(bo_we), 64'd0);
        got.delete();
        send(32'h12, 8, 1'b0);
        wait_idle();
        check_seq("t6_bytes", 1, 8'h12, 8'h00, 8'h00, 8'h00);

        // Random codes, lengths (incl. clamped), markers and backpressure
        rand_bp = 1'b1;
        for (int n = 0; n < 400; n++) begin
            int r;
            r = $urandom_range(0, 19);
            if (r == 0) begin
                r = $urandom_range(0, 8);
                send((r == 8) ? 32'hD9 : 32'(8'hD0 + r), $urandom_range(0, 40), 1'b1);
            end else begin
                send($urandom, $urandom_range(0, 40), 1'b0);
            end
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
        end
        send(32'hD9, 0, 1'b1);
        wait_idle();
        chk("rand_model_empty", 64'(expq.size()), 64'd0);
        chk("rand_bits_left", 64'(bq.size()), 64'd0);
        if (got.size() >= 2) begin
            chk("rand_tail_ff", 64'(got[got.size()-2]), 64'hFF);
            chk("rand_tail_eoi", 64'(got[got.size()-1]), 64'hD9);
        end else begin
            chk("rand_byte_count", 64'(got.size()), 64'd2);
        end
        rand_bp = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

endmodule : tb_jpeg_bitpack
`default_nettype wire
